// File: rtl/traffic_ctrl_timed.sv
// Highway/country junction controller with counted phases, min/max greens and all-red clearance.
// Define TRAFFIC_PED_WALK_EN to add the ped_req input and ped_walk indicator.
module traffic_ctrl_timed #(
    parameter int unsigned YEL_CYC       = 3,
    parameter int unsigned ALLRED_CYC    = 2,
    parameter int unsigned HWY_MIN_GRN   = 8,
    parameter int unsigned CNTRY_MAX_GRN = 10,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       ce,
    input  logic       X,
`ifdef TRAFFIC_PED_WALK_EN
    input  logic       ped_req,
    output logic       ped_walk,
`endif
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic [2:0] phase
);

    localparam logic [1:0] RED = 2'd0;
    localparam logic [1:0] YEL = 2'd1;
    localparam logic [1:0] GRN = 2'd2;

    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YEL_CYC - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] HMIN_LAST = CNT_W'(HWY_MIN_GRN - 1);
    localparam logic [CNT_W-1:0] CMAX_LAST = CNT_W'(CNTRY_MAX_GRN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        HG  = 3'd0,
        HY  = 3'd1,
        AR1 = 3'd2,
        CG  = 3'd3,
        CY  = 3'd4,
        AR2 = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             demand_q, demand_d;
    logic [1:0]       hwy_q, hwy_d;
    logic [1:0]       cntry_q, cntry_d;
    logic [2:0]       phase_q;
    logic             req_c;
    logic             cg_exit_ok_c;

`ifdef TRAFFIC_PED_WALK_EN
    logic ped_dem_q, ped_dem_d;
    logic ped_walk_q;

    assign req_c = X | ped_req;
    // A pedestrian-driven demand keeps CG up for at least a yellow duration.
    assign cg_exit_ok_c = !ped_dem_q || (cnt_q >= YEL_LAST);
`else
    assign req_c        = X;
    assign cg_exit_ok_c = 1'b1;
`endif

    // Next-state, phase counter and demand latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HG:  if (ce && (cnt_q >= HMIN_LAST) && (demand_q || req_c)) state_d = HY;
            HY:  if (ce && (cnt_q == YEL_LAST))  state_d = AR1;
            AR1: if (ce && (cnt_q == AR_LAST))   state_d = CG;
            CG:  if (ce && ((!X && cg_exit_ok_c) || (cnt_q == CMAX_LAST))) state_d = CY;
            CY:  if (ce && (cnt_q == YEL_LAST))  state_d = AR2;
            AR2: if (ce && (cnt_q == AR_LAST))   state_d = HG;
            default: state_d = HG;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (ce && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        if ((state_q != CG) && (state_d == CG)) begin
            demand_d = 1'b0;
        end else if (req_c && (state_q != CG)) begin
            demand_d = 1'b1;
        end else begin
            demand_d = demand_q;
        end
    end

`ifdef TRAFFIC_PED_WALK_EN
    always_comb begin
        ped_dem_d = ped_dem_q;
        if ((state_q == CG) && (state_d != CG)) begin
            ped_dem_d = 1'b0;
        end else if (ped_req && (state_q != CG)) begin
            ped_dem_d = 1'b1;
        end
    end
`endif

    // Lamp decode of the upcoming state so registered lamps track the state register.
    always_comb begin
        hwy_d   = RED;
        cntry_d = RED;
        case (state_d)
            HG:      hwy_d   = GRN;
            HY:      hwy_d   = YEL;
            CG:      cntry_d = GRN;
            CY:      cntry_d = YEL;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q    <= HG;
            cnt_q      <= '0;
            demand_q   <= 1'b0;
            hwy_q      <= GRN;
            cntry_q    <= RED;
            phase_q    <= 3'd0;
`ifdef TRAFFIC_PED_WALK_EN
            ped_dem_q  <= 1'b0;
            ped_walk_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            demand_q   <= demand_d;
            hwy_q      <= hwy_d;
            cntry_q    <= cntry_d;
            phase_q    <= 3'(state_d);
`ifdef TRAFFIC_PED_WALK_EN
            ped_dem_q  <= ped_dem_d;
            ped_walk_q <= (state_d == CG);
`endif
        end
    end

    assign hwy   = hwy_q;
    assign cntry = cntry_q;
    assign phase = phase_q;
`ifdef TRAFFIC_PED_WALK_EN
    assign ped_walk = ped_walk_q;
`endif

endmodule

// File: tb/tb_traffic_ctrl_timed.sv
// Self-checking bench for traffic_ctrl_timed: phase timelines scoreboarded per cycle plus random safety checks.
module tb_traffic_ctrl_timed;

    logic       clk = 1'b0;
    logic       clear;
    logic       ce;
    logic       x_in;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic [2:0] phase;
`ifdef TRAFFIC_PED_WALK_EN
    logic       ped_req;
    logic       ped_walk;
`endif

    int checks   = 0;
    int failures = 0;
    logic [6:0] exp_q[$];

    always #5 clk = ~clk;

    traffic_ctrl_timed dut (
        .clk     (clk),
        .clear   (clear),
        .ce      (ce),
        .X       (x_in),
`ifdef TRAFFIC_PED_WALK_EN
        .ped_req (ped_req),
        .ped_walk(ped_walk),
`endif
        .hwy     (hwy),
        .cntry   (cntry),
        .phase   (phase)
    );

    // Expected {hwy, cntry, phase} for a phase code.
    function automatic logic [6:0] exp_of(input logic [2:0] p);
        case (p)
            3'd0:    return {2'd2, 2'd0, p};
            3'd1:    return {2'd1, 2'd0, p};
            3'd2:    return {2'd0, 2'd0, p};
            3'd3:    return {2'd0, 2'd2, p};
            3'd4:    return {2'd0, 2'd1, p};
            default: return {2'd0, 2'd0, p};
        endcase
    endfunction

    task automatic push_seg(input logic [2:0] p, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(exp_of(p));
    endtask

    task automatic do_reset();
        clear = 1'b1;
        ce    = 1'b1;
        x_in  = 1'b0;
        repeat (2) @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] got;
        logic [6:0] exp;
        do_reset();
        got = {hwy, cntry, phase};
        checks++;
        if (got !== 7'b10_00_000) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", got, 7'b10_00_000);
        end
        push_seg(3'd0, 50);
        for (int c = 0; c < 50; c++) begin
            exp = exp_q.pop_front();
            got = {hwy, cntry, phase};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL idle_hg cyc=%0d got=%b exp=%b", c, got, exp);
            end
            ce   = 1'b1;
            x_in = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_early_car();
        logic [6:0] got;
        logic [6:0] exp;
        do_reset();
        push_seg(3'd0, 8); push_seg(3'd1, 3); push_seg(3'd2, 2); push_seg(3'd3, 1);
        push_seg(3'd4, 3); push_seg(3'd5, 2); push_seg(3'd0, 10);
        for (int c = 0; c < 29; c++) begin
            exp = exp_q.pop_front();
            got = {hwy, cntry, phase};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL early_car cyc=%0d got=%b exp=%b", c, got, exp);
            end
            x_in = (c == 2);
            @(negedge clk);
        end
    endtask

    task automatic test_max_green();
        logic [6:0] got;
        logic [6:0] exp;
        do_reset();
        push_seg(3'd0, 8); push_seg(3'd1, 3); push_seg(3'd2, 2); push_seg(3'd3, 10);
        push_seg(3'd4, 3); push_seg(3'd5, 2); push_seg(3'd0, 8); push_seg(3'd1, 3);
        for (int c = 0; c < 39; c++) begin
            exp = exp_q.pop_front();
            got = {hwy, cntry, phase};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL max_green cyc=%0d got=%b exp=%b", c, got, exp);
            end
            x_in = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_ce_gating();
        logic [6:0] got;
        logic [6:0] exp;
        do_reset();
        push_seg(3'd0, 32); push_seg(3'd1, 12); push_seg(3'd2, 8); push_seg(3'd3, 40);
        push_seg(3'd4, 12); push_seg(3'd5, 8); push_seg(3'd0, 32); push_seg(3'd1, 4);
        for (int c = 0; c < 148; c++) begin
            exp = exp_q.pop_front();
            got = {hwy, cntry, phase};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL ce_gating cyc=%0d got=%b exp=%b", c, got, exp);
            end
            x_in = 1'b1;
            ce   = ((c % 4) == 3);
            @(negedge clk);
        end
        ce = 1'b1;
    endtask

    task automatic test_mid_reset();
        logic [6:0] got;
        logic [6:0] exp;
        do_reset();
        push_seg(3'd0, 8); push_seg(3'd1, 3); push_seg(3'd2, 2); push_seg(3'd3, 6);
        push_seg(3'd0, 20);
        for (int c = 0; c < 39; c++) begin
            exp = exp_q.pop_front();
            got = {hwy, cntry, phase};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL mid_reset cyc=%0d got=%b exp=%b", c, got, exp);
            end
            x_in  = (c < 18);
            clear = (c == 18);
            @(negedge clk);
        end
        clear = 1'b0;
    endtask

    task automatic test_random_safety();
        logic [6:0] cur;
        logic [6:0] prev;
        logic       prev_clr;
        logic       prev_ce;
        do_reset();
        prev     = {hwy, cntry, phase};
        prev_clr = 1'b1;
        prev_ce  = 1'b1;
        for (int c = 0; c < 600; c++) begin
            cur = {hwy, cntry, phase};
            checks++;
            if (hwy == 2'd2 && cntry == 2'd2) begin
                failures++;
                $display("FAIL both_green cyc=%0d got hwy=%0d cntry=%0d exp=not_both_2", c, hwy, cntry);
            end
            if (!prev_clr) begin
                checks++;
                if ((prev[6:5] == 2'd2 && cur[6:5] == 2'd0) || (prev[4:3] == 2'd2 && cur[4:3] == 2'd0)) begin
                    failures++;
                    $display("FAIL green_to_red cyc=%0d got=%b prev=%b exp=yellow_between", c, cur, prev);
                end
                if (!prev_ce) begin
                    checks++;
                    if (cur !== prev) begin
                        failures++;
                        $display("FAIL ce_freeze cyc=%0d got=%b exp=%b", c, cur, prev);
                    end
                end
            end
            prev     = cur;
            x_in     = 1'($urandom_range(0, 1));
            ce       = ($urandom_range(0, 3) != 0);
            clear    = ($urandom_range(0, 49) == 0);
            prev_clr = clear;
            prev_ce  = ce;
            @(negedge clk);
        end
        clear = 1'b0;
        ce    = 1'b1;
    endtask

    initial begin
        clear = 1'b1;
        ce    = 1'b1;
        x_in  = 1'b0;
`ifdef TRAFFIC_PED_WALK_EN
        ped_req = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_early_car();
        test_max_green();
        test_ce_gating();
        test_mid_reset();
        test_random_safety();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
